// File: rtl/usb_status_pkg.sv
// Shared display-mode encoding and LED bank layout for the USB status LED block.
package usb_status_pkg;

  typedef enum logic [1:0] {
    MODE_STATUS    = 2'd0,
    MODE_TYPE      = 2'd1,
    MODE_COUNT     = 2'd2,
    MODE_HEARTBEAT = 2'd3
  } mode_t;

  localparam int LED_W    = 8;
  localparam int ERR_BASE = 4;
  localparam int MAX_NCH  = 4;

  // Button presses walk the modes in a ring.
  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// Stretches a one-cycle trigger into a LEN-cycle registered activity pulse; output lags trigger by 1 cycle.
// A retrigger reloads the full length, so a pulse never ends early.
module led_pulse_stretch #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic active
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LEN - 1);

  logic [CW-1:0] cnt;

  // The trigger cycle itself counts as the first active cycle, hence LEN-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      active <= trig | (cnt != '0);
      if (trig)
        cnt <= LOAD;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/usb_status_leds.sv
// Multi-channel HID status LEDs: report counters, stretched activity, sticky errors, button-selected view.
// Report strobe reaches led 2 cycles later; a debounced press reaches mode 1 cycle later, led 1 after that.
module usb_status_leds
  import usb_status_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int CNT_W       = 7,
  parameter int STRETCH_CYC = 1200000,
  parameter int DEB_CYC     = 120000,
  parameter int HB_W        = 23
) (
  input  logic               usbclk,
  input  logic               usbrst_n,
  input  logic [2*NCH-1:0]   typ,
  input  logic [NCH-1:0]     report,
  input  logic [NCH-1:0]     conerr,
  input  logic               mode_btn,
  input  logic               clr_err,
  input  logic [1:0]         ch_sel,
  output logic [LED_W-1:0]   led,
  output logic [1:0]         mode
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic             rst_meta;
  logic             rst_n;
  logic [CNT_W-1:0] rpt_cnt [NCH];
  logic [NCH-1:0]   active;
  logic [NCH-1:0]   err_q;
  logic             btn_meta;
  logic             btn_sync;
  logic             btn_deb;
  logic [DW-1:0]    deb_cnt;
  logic             deb_rise;
  mode_t            mode_q;
  logic [HB_W-1:0]  hb;
  logic [LED_W-1:0] led_nxt;

  // Reset asserts immediately but releases in step with usbclk.
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++)
        rpt_cnt[i] <= '0;
      err_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (report[i])
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
      end
      // An error still present wins over a clear request.
      err_q <= conerr | (err_q & ~{NCH{clr_err}});
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_stretch
    led_pulse_stretch #(.LEN(STRETCH_CYC)) u_stretch (
      .clk    (usbclk),
      .rst_n  (rst_n),
      .trig   (report[g]),
      .active (active[g])
    );
  end

  // Any disagreement with the debounced level must persist DEB_CYC samples in a row.
  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_deb  <= 1'b0;
      deb_cnt  <= '0;
      deb_rise <= 1'b0;
    end else begin
      btn_meta <= mode_btn;
      btn_sync <= btn_meta;
      deb_rise <= 1'b0;
      if (btn_sync == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_deb  <= btn_sync;
        deb_cnt  <= '0;
        deb_rise <= btn_sync;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n)
      mode_q <= MODE_STATUS;
    else if (deb_rise)
      mode_q <= next_mode(mode_q);
  end

  assign mode = mode_q;

  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n)
      hb <= '0;
    else
      hb <= hb + 1'b1;
  end

  always_comb begin
    led_nxt = '0;
    case (mode_q)
      MODE_STATUS: begin
        for (int i = 0; i < NCH; i++) begin
          led_nxt[i]            = active[i];
          led_nxt[ERR_BASE + i] = err_q[i];
        end
      end
      MODE_TYPE: begin
        for (int i = 0; i < NCH; i++)
          led_nxt[2*i +: 2] = typ[2*i +: 2];
      end
      MODE_COUNT: begin
        // Unpopulated channel selections fall through to a dark bank.
        for (int i = 0; i < NCH; i++) begin
          if (ch_sel == 2'(i))
            led_nxt = LED_W'(rpt_cnt[i]);
        end
      end
      MODE_HEARTBEAT: begin
        led_nxt[0]   = hb[HB_W-1];
        led_nxt[7:4] = {4{|err_q}};
      end
      default: led_nxt = '0;
    endcase
  end

  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n)
      led <= '0;
    else
      led <= led_nxt;
  end

endmodule

// File: tb/tb_usb_status_leds.sv
// Scoreboard bench for usb_status_leds with short stretch/debounce/heartbeat settings.
module tb_usb_status_leds;

  logic       usbclk   = 1'b0;
  logic       usbrst_n = 1'b1;
  logic [3:0] typ;
  logic [1:0] report;
  logic [1:0] conerr;
  logic       mode_btn;
  logic       clr_err;
  logic [1:0] ch_sel;
  logic [7:0] led;
  logic [1:0] mode;

  typedef struct {
    int         cyc;
    logic [7:0] exp_led;
    logic [7:0] mask;
    logic       chk_mode;
    logic [1:0] exp_mode;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 usbclk = ~usbclk;
  always @(posedge usbclk) cyc <= cyc + 1;

  usb_status_leds #(
    .NCH         (2),
    .CNT_W       (7),
    .STRETCH_CYC (4),
    .DEB_CYC     (3),
    .HB_W        (4)
  ) dut (
    .usbclk   (usbclk),
    .usbrst_n (usbrst_n),
    .typ      (typ),
    .report   (report),
    .conerr   (conerr),
    .mode_btn (mode_btn),
    .clr_err  (clr_err),
    .ch_sel   (ch_sel),
    .led      (led),
    .mode     (mode)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge usbclk);
    #1;
  endtask

  // Expectation for the clock interval dc cycles from now, sampled at its falling edge.
  task automatic expect_at(input int dc, input string nm, input logic [7:0] e,
                           input logic [7:0] m, input logic cm, input logic [1:0] em);
    exp_t x;
    x.cyc      = cyc + dc;
    x.exp_led  = e;
    x.mask     = m;
    x.chk_mode = cm;
    x.exp_mode = em;
    x.name     = nm;
    sb.push_back(x);
  endtask

  task automatic press(input int hi, input int lo);
    mode_btn = 1'b1;
    tick(hi);
    mode_btn = 1'b0;
    tick(lo);
  endtask

  initial begin : monitor
    int i;
    forever begin
      @(negedge usbclk);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if ((((led ^ sb[i].exp_led) & sb[i].mask) != 8'h00) ||
              (sb[i].chk_mode && (mode != sb[i].exp_mode))) begin
            errors++;
            $display("FAIL %s @cyc %0d: led=%h mode=%0d, expected led=%h (mask %h) mode=%0d%s",
                     sb[i].name, cyc, led, mode, sb[i].exp_led, sb[i].mask,
                     sb[i].exp_mode, sb[i].chk_mode ? "" : " (mode not checked)");
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                   sb[i].name, sb[i].cyc, cyc);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin : stimulus
    typ      = 4'b0110;
    report   = 2'b00;
    conerr   = 2'b00;
    mode_btn = 1'b0;
    clr_err  = 1'b0;
    ch_sel   = 2'd0;
    #2 usbrst_n = 1'b0;
    tick(3);
    expect_at(0, "reset_hold", 8'h00, 8'hFF, 1'b1, 2'd0);
    tick(1);
    usbrst_n = 1'b1;
    tick(5);
    expect_at(0, "reset_state", 8'h00, 8'hFF, 1'b1, 2'd0);
    tick(1);

    // Single strobe: led[0] high for intervals +2..+5 only.
    for (int k = 0; k < 8; k++)
      expect_at(k, "single_pulse", (k >= 2 && k <= 5) ? 8'h01 : 8'h00, 8'hFF, 1'b1, 2'd0);
    report = 2'b01;
    tick(1);
    report = 2'b00;
    tick(10);

    // Retrigger two cycles apart: continuous until 4 cycles after the last strobe.
    for (int k = 0; k < 10; k++)
      expect_at(k, "retrigger", (k >= 2 && k <= 7) ? 8'h01 : 8'h00, 8'hFF, 1'b1, 2'd0);
    report = 2'b01;
    tick(1);
    report = 2'b00;
    tick(1);
    report = 2'b01;
    tick(1);
    report = 2'b00;
    tick(12);

    // Sticky error latch on channel 1.
    conerr = 2'b10;
    expect_at(1, "err_latency", 8'h00, 8'hFF, 1'b1, 2'd0);
    expect_at(2, "err_set", 8'h20, 8'hFF, 1'b1, 2'd0);
    tick(5);
    conerr = 2'b00;
    tick(5);
    expect_at(0, "err_sticky", 8'h20, 8'hFF, 1'b1, 2'd0);
    tick(1);
    clr_err = 1'b1;
    conerr  = 2'b10;
    expect_at(3, "err_clr_blocked", 8'h20, 8'hFF, 1'b1, 2'd0);
    tick(1);
    clr_err = 1'b0;
    conerr  = 2'b00;
    tick(4);
    clr_err = 1'b1;
    expect_at(1, "err_before_clr", 8'h20, 8'hFF, 1'b1, 2'd0);
    expect_at(2, "err_cleared", 8'h00, 8'hFF, 1'b1, 2'd0);
    tick(1);
    clr_err = 1'b0;
    tick(4);

    // 130 strobes on channel 1 wrap the 7-bit counter to 2.
    report = 2'b10;
    tick(130);
    report = 2'b00;
    tick(10);

    // Glitches shorter than the debounce window must not change mode.
    mode_btn = 1'b1;
    tick(1);
    mode_btn = 1'b0;
    tick(1);
    mode_btn = 1'b1;
    tick(1);
    mode_btn = 1'b0;
    tick(8);
    expect_at(0, "bounce_ignored", 8'h00, 8'hFF, 1'b1, 2'd0);
    tick(1);

    press(6, 8);
    expect_at(0, "mode_type", 8'h06, 8'hFF, 1'b1, 2'd1);
    tick(1);
    press(6, 8);
    expect_at(0, "count_ch0", 8'h03, 8'hFF, 1'b1, 2'd2);
    tick(1);
    ch_sel = 2'd1;
    tick(2);
    expect_at(0, "count_ch1_wrap", 8'h02, 8'hFF, 1'b1, 2'd2);
    tick(1);
    ch_sel = 2'd3;
    tick(2);
    expect_at(0, "count_ch3_empty", 8'h00, 8'hFF, 1'b1, 2'd2);
    tick(1);
    ch_sel = 2'd2;
    tick(2);
    expect_at(0, "count_ch2_empty", 8'h00, 8'hFF, 1'b1, 2'd2);
    tick(1);

    conerr = 2'b01;
    tick(3);
    press(6, 8);
    expect_at(0, "heartbeat_err", 8'hF0, 8'hFE, 1'b1, 2'd3);
    tick(1);
    press(6, 8);
    expect_at(0, "wrap_to_status", 8'h10, 8'hFF, 1'b1, 2'd0);
    tick(1);
    press(6, 8);
    expect_at(0, "seq_type", 8'h06, 8'hFF, 1'b1, 2'd1);
    tick(1);
    press(6, 8);
    expect_at(0, "seq_count", 8'h00, 8'hFF, 1'b1, 2'd2);
    tick(1);
    press(6, 8);
    expect_at(0, "seq_heartbeat", 8'hF0, 8'hFE, 1'b1, 2'd3);
    tick(1);

    // Reset mid-stretch in heartbeat mode clears outputs without a clock edge.
    report = 2'b01;
    tick(1);
    report = 2'b00;
    tick(2);
    usbrst_n = 1'b0;
    conerr   = 2'b00;
    ch_sel   = 2'd1;
    expect_at(0, "async_reset", 8'h00, 8'hFF, 1'b1, 2'd0);
    tick(1);
    expect_at(0, "reset_held", 8'h00, 8'hFF, 1'b1, 2'd0);
    tick(2);
    usbrst_n = 1'b1;
    tick(6);
    expect_at(0, "post_reset", 8'h00, 8'hFF, 1'b1, 2'd0);
    tick(1);
    press(6, 8);
    press(6, 8);
    expect_at(0, "count_after_reset", 8'h00, 8'hFF, 1'b1, 2'd2);
    tick(1);

    for (int k = 0; k < 20 && sb.size() > 0; k++)
      tick(1);
    if (sb.size() > 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_status_leds.md
Name: usb_status_leds

Overview:
- Parametrised successor to the single-channel report-blink LED logic in the board tops.
- Monitors NCH usb_hid_host instances and drives an 8-bit LED bank.
- Per-channel report counters, visible activity pulse stretching and sticky connection-error latches.
- Debounced button cycles four display modes.

Parameters:
- NCH, 2: number of monitored HID channels, legal 1..4
- CNT_W, 7: per-channel report counter width, legal 1..16
- STRETCH_CYC, 1200000: activity pulse length in usbclk cycles (100 ms at 12 MHz), >=1
- DEB_CYC, 120000: button debounce stability time in cycles (10 ms), >=1
- HB_W, 23: heartbeat divider width

Ports:
- usbclk  in  1  sole clock (12 MHz)
- usbrst_n  in  1  asynchronous active-low reset
- typ  in  2*NCH  packed device type per channel, ch i at [2i+1:2i]
- report  in  NCH  one-cycle report strobe per channel
- conerr  in  NCH  connection error level per channel
- mode_btn  in  1  raw asynchronous button, active-high
- clr_err  in  1  synchronous error-latch clear, active-high
- ch_sel  in  2  channel shown in COUNT mode, quasi-static
- led  out  8  LED drive, registered
- mode  out  2  current display mode, registered

Behaviour:
- Reset (async assert, sync release): all counters 0, stretchers 0, err latches 0, mode=0, led=0, debounce state 0, heartbeat 0.
- Report counter[i]: +1 on every cycle report[i]=1; wraps 2^CNT_W-1 -> 0; no saturation.
- Stretcher[i]: report[i]=1 loads STRETCH_CYC-1 and sets active[i]=1. Otherwise decrements to 0. active[i]=1 while count>0 or on the load cycle. A retrigger while active reloads the full value; a pulse never ends early.
- Err latch[i]: set while conerr[i]=1. clr_err clears it only when conerr[i]=0; simultaneous set and clear -> set wins.
- Button path: 2-FF synchroniser, then a stability counter. A level change held DEB_CYC consecutive cycles updates the debounced level; any bounce restarts the count.
- Debounced rising edge advances mode 0->1->2->3->0. The falling edge does nothing.
- Mode 0 STATUS: led[i]=active[i] for i<NCH; led[4+i]=err[i]; unused bits 0.
- Mode 1 TYPE: led[2i+1:2i]=typ ch i for i<NCH; unused bits 0.
- Mode 2 COUNT: led = counter[ch_sel], zero-extended if CNT_W<8, low 8 bits if wider. ch_sel>=NCH -> led=0.
- Mode 3 HEARTBEAT: led[0]=heartbeat[HB_W-1]; led[7:4]=OR-reduce of err latches replicated across all four bits; others 0.
- Latency, report strobe at cycle N: counter and active update at N+1; led reflects it at N+2.
- Latency, button edge: mode updates 1 cycle after the debounce decision; led follows 1 cycle after mode.
- Reset mid-pulse or mid-debounce: everything returns to reset values; no pending mode change survives.
- Inputs typ, report, conerr and clr_err are synchronous to usbclk and are not resynchronised.

Decomposition:
- Package usb_status_pkg holds:
  - MODE_STATUS=0, MODE_TYPE=1, MODE_COUNT=2, MODE_HEARTBEAT=3
  - LED_W=8
  - ERR_BASE=4
  - MAX_NCH=4
- Sub-module led_pulse_stretch (param LEN): one stretcher, instantiated NCH times via generate.
- Debounce and mode FSM stay in the top of the block.

Test Plan (STRETCH_CYC=4, DEB_CYC=3, HB_W=4, NCH=2, CNT_W=7):
- Reset, then single report[0] pulse in mode 0 -> led[0]=1 for exactly 4 cycles starting 2 cycles after the strobe; led[1]=0 throughout.
- report[0] pulses 2 cycles apart -> led[0] held high continuously until 4 cycles after the last pulse.
- 130 report[1] strobes, mode 2, ch_sel=1 -> led=8'h02 (wrap at 128). ch_sel=3 -> led=8'h00.
- Button bounce 1,0,1 (1-cycle glitches), then held high 3+ cycles -> mode advances exactly once (0->1). Hold low, then press 3 more times -> mode sequence 2,3,0.
- conerr[1] high 5 cycles, then low -> led[5]=1 sticky in mode 0. clr_err while conerr[1]=1 -> stays 1. clr_err after conerr low -> led[5]=0.
- usbrst_n asserted mid-stretch in mode 3 -> led=0 and mode=0 immediately, without waiting for a clock edge.
